timer_load_control: RTL and testbench
=====================================

Name: timer_load_control

Overview:
- Upstream controller for the chained single-digit countdown timers.
- Sequences operator digit entry into each digit stage, most significant digit first, using one-hot load strobes and a shared digit bus.
- Generates the prescaled decrement tick that drives the chain, and handles start/pause/resume.
- Stops ticking when the chain reports timeout.

Parameters:
- DIGITS, 4, number of digit stages driven; width of loadEn.
- TICK_DIV, 1000, clock cycles per decrement tick; must be >= 2.
- CNT_W, 10, prescaler counter width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- digitIn  input  4  operator digit value (BCD; values >9 passed through unchanged, the digit stage clamps them).
- loadBtn  input  1  one-cycle pulse: latch digitIn into the current digit position.
- startBtn  input  1  one-cycle pulse: start / pause / resume toggle.
- timeout  input  1  timeout flag from the digit chain (the most significant stage's TOut), synchronous to clk.
- binaryInp  output  4  registered digit value presented to all stages.
- loadEn  output  DIGITS  registered one-hot load strobe; bit DIGITS-1 = most significant digit.
- decTick  output  1  registered one-cycle decrement pulse to the chain.
- running  output  1  high while in RUN.
- done  output  1  high while in DONE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; digit pointer=DIGITS-1; prescaler=0.
  - binaryInp=0, loadEn=0, decTick=0, running=0, done=0.
- Outputs are registered. loadEn, binaryInp and decTick change one cycle after the qualifying input is sampled.
- loadEn and decTick are high for exactly one cycle per event; otherwise 0. binaryInp holds its last value.
- Priority when inputs coincide: loadBtn > timeout > startBtn.
- IDLE:
  - loadBtn: binaryInp<=digitIn, loadEn<=one-hot(DIGITS-1), pointer<=DIGITS-2, go ENTRY.
  - startBtn ignored.
- ENTRY:
  - loadBtn: binaryInp<=digitIn, loadEn<=one-hot(pointer).
  - If pointer==0, go READY and reset pointer to DIGITS-1; else decrement pointer.
  - startBtn ignored (a partial entry cannot start).
- READY:
  - startBtn: go RUN, prescaler<=0.
  - loadBtn: restart entry. Load the MSD exactly as in IDLE, pointer<=DIGITS-2, go ENTRY.
- RUN:
  - timeout=1: go DONE. No decTick is issued that cycle, even if the prescaler is at terminal count.
  - Otherwise, prescaler==TICK_DIV-1: prescaler<=0 and decTick<=1. Any other value: prescaler increments.
  - With prescaler cleared on entry, the first decTick is high in cycle TICK_DIV after the start edge, then every TICK_DIV cycles.
  - startBtn without timeout: go PAUSE, prescaler held, no tick.
  - loadBtn: abort and restart entry (MSD load, go ENTRY); prescaler<=0.
- PAUSE:
  - Prescaler frozen.
  - startBtn: go RUN, resuming from the frozen prescaler value.
  - loadBtn: restart entry as above.
  - timeout ignored.
- DONE:
  - done=1, no ticks, startBtn ignored.
  - loadBtn: restart entry as above.
- Starting with an all-zero load: timeout is already 1, so RUN lasts one cycle, then DONE with zero ticks issued.
- Reset mid-operation: everything returns immediately to reset values. A pending loadEn/decTick pulse is dropped.
- Prescaler never exceeds TICK_DIV-1.

Test Plan:
- Reset/entry, DIGITS=4:
  - Stimulus: hold rst=0 for 3 cycles, release. Then four loadBtn pulses with digitIn=1,2,3,4.
  - Required: loadEn=1000,0100,0010,0001 on successive load responses; binaryInp=1,2,3,4 in the same cycles; state READY after the fourth.
- Tick cadence, TICK_DIV=4:
  - Stimulus: startBtn from READY, timeout=0.
  - Required: running=1; decTick high in cycles 4, 8, 12 after the start edge, one cycle wide each.
- Pause/resume, TICK_DIV=4:
  - Stimulus: startBtn 2 cycles after RUN entry; wait 10 cycles; startBtn again.
  - Required: no decTick during pause; next decTick 2 cycles after resume.
- Timeout vs terminal count:
  - Stimulus: assert timeout in the cycle the prescaler equals TICK_DIV-1.
  - Required: no decTick; done=1 next cycle; later startBtn has no effect.
- Re-entry priority:
  - Stimulus: in RUN, pulse loadBtn and startBtn together with digitIn=7.
  - Required: loadEn=1000, binaryInp=7, running=0, state ENTRY.
- Async reset mid-RUN:
  - Stimulus: drop rst between clock edges.
  - Required: all outputs 0 immediately, without waiting for a clock edge; the next loadBtn targets the MSD.

Source files
------------

// File: rtl/timer_load_control.sv
// timer_load_control
//   Upstream controller for a chain of single-digit countdown timers.
//   Sequences operator digit entry (most significant digit first) onto a
//   shared digit bus with one-hot load strobes, then generates the
//   prescaled decrement tick for the chain with start/pause/resume, and
//   stops ticking once the chain reports timeout.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   digitIn    operator digit (BCD; values > 9 passed through unchanged)
//   loadBtn    one-cycle pulse: latch digitIn into the current digit
//   startBtn   one-cycle pulse: start / pause / resume toggle
//   timeout    timeout flag from the most significant stage of the chain
//   binaryInp  registered digit value presented to all stages
//   loadEn     registered one-hot load strobe, bit DIGITS-1 = MSD
//   decTick    registered one-cycle decrement pulse
//   running    high while counting
//   done       high after timeout, until a new entry begins
module timer_load_control #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned CNT_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        digitIn,
  input  logic              loadBtn,
  input  logic              startBtn,
  input  logic              timeout,
  output logic [3:0]        binaryInp,
  output logic [DIGITS-1:0] loadEn,
  output logic              decTick,
  output logic              running,
  output logic              done
);

  localparam int unsigned PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PTR_W-1:0]  PTR_MSD   = PTR_W'(DIGITS - 1);
  localparam logic [PTR_W-1:0]  PTR_NEXT  = (DIGITS > 1) ? PTR_W'(DIGITS - 2) : '0;
  localparam logic [DIGITS-1:0] EN_MSD    = DIGITS'(1) << (DIGITS - 1);
  localparam logic [CNT_W-1:0]  PRESC_TC  = CNT_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_READY,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  presc_q, presc_d;
  logic [3:0]        bin_q, bin_d;
  logic [DIGITS-1:0] en_q, en_d;
  logic              tick_q, tick_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    presc_d = presc_q;
    bin_d   = bin_q;
    en_d    = '0;
    tick_d  = 1'b0;

    // loadBtn outranks everything: outside ENTRY it always (re)starts entry
    // at the MSD, aborting any run in progress.
    if (loadBtn && state_q != S_ENTRY) begin
      bin_d   = digitIn;
      en_d    = EN_MSD;
      presc_d = '0;
      if (DIGITS == 1) begin
        state_d = S_READY;
        ptr_d   = PTR_MSD;
      end else begin
        state_d = S_ENTRY;
        ptr_d   = PTR_NEXT;
      end
    end else begin
      unique case (state_q)
        S_ENTRY: begin
          if (loadBtn) begin
            bin_d = digitIn;
            en_d  = DIGITS'(1) << ptr_q;
            if (ptr_q == '0) begin
              state_d = S_READY;
              ptr_d   = PTR_MSD;
            end else begin
              ptr_d = ptr_q - 1'b1;
            end
          end
        end
        S_READY: begin
          if (startBtn) begin
            state_d = S_RUN;
            presc_d = '0;
          end
        end
        S_RUN: begin
          // Timeout wins over both the pause request and a terminal-count tick.
          if (timeout) begin
            state_d = S_DONE;
          end else if (startBtn) begin
            state_d = S_PAUSE;
          end else if (presc_q == PRESC_TC) begin
            presc_d = '0;
            tick_d  = 1'b1;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        S_PAUSE: begin
          if (startBtn) begin
            state_d = S_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= PTR_MSD;
      presc_q <= '0;
      bin_q   <= '0;
      en_q    <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      presc_q <= presc_d;
      bin_q   <= bin_d;
      en_q    <= en_d;
      tick_q  <= tick_d;
    end
  end

  assign binaryInp = bin_q;
  assign loadEn    = en_q;
  assign decTick   = tick_q;
  assign running   = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_timer_load_control.sv
module tb_timer_load_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digitIn;
  logic       loadBtn;
  logic       startBtn;
  logic       timeout;
  logic [3:0] binaryInp;
  logic [3:0] loadEn;
  logic       decTick;
  logic       running;
  logic       done;

  timer_load_control #(
    .DIGITS  (4),
    .TICK_DIV(4),
    .CNT_W   (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .digitIn  (digitIn),
    .loadBtn  (loadBtn),
    .startBtn (startBtn),
    .timeout  (timeout),
    .binaryInp(binaryInp),
    .loadEn   (loadEn),
    .decTick  (decTick),
    .running  (running),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Count of rising edges; at a falling edge it names the edge just taken.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int       at;
    bit       tick;
    bit [3:0] en;
    bit [3:0] bin;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_tick(input int at);
    exp_q.push_back('{at: at, tick: 1'b1, en: 4'b0000, bin: 4'd0});
  endtask

  // Called on a falling edge; the strobe is expected after the next rising edge.
  task automatic do_load(input logic [3:0] d, input logic [3:0] exp_en);
    digitIn = d;
    loadBtn = 1'b1;
    exp_q.push_back('{at: cyc + 1, tick: 1'b0, en: exp_en, bin: d});
    @(negedge clk);
    loadBtn = 1'b0;
  endtask

  task automatic do_start();
    startBtn = 1'b1;
    @(negedge clk);
    startBtn = 1'b0;
  endtask

  task automatic to_neg(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (loadEn != 4'b0000 || decTick) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {27'd0, decTick, loadEn}, 0);
        end else begin
          e = exp_q.pop_front();
          check(e.tick ? "tick_cycle" : "load_cycle", cyc, e.at);
          check("decTick", int'(decTick), int'(e.tick));
          check("loadEn", int'(loadEn), int'(e.en));
          if (!e.tick) check("binaryInp", int'(binaryInp), int'(e.bin));
        end
      end
    end
  endtask

  int s, p, s2, t, s3;

  initial begin
    rst = 1'b0; digitIn = '0; loadBtn = 1'b0; startBtn = 1'b0; timeout = 1'b0;
    fork
      monitor();
    join_none

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_loadEn", int'(loadEn), 0);
    check("rst_binaryInp", int'(binaryInp), 0);
    check("rst_decTick", int'(decTick), 0);
    check("rst_running", int'(running), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b1;
    @(negedge clk);

    // startBtn ignored in IDLE.
    do_start();
    @(negedge clk);
    check("idle_start_running", int'(running), 0);

    // Entry, MSD first; a start mid-entry is ignored.
    do_load(4'd1, 4'b1000);
    do_load(4'd2, 4'b0100);
    do_start();
    check("entry_start_running", int'(running), 0);
    do_load(4'd3, 4'b0010);
    do_load(4'd4, 4'b0001);
    @(negedge clk);
    check("loadEn_one_cycle", int'(loadEn), 0);
    check("binaryInp_hold", int'(binaryInp), 4);

    // Tick cadence: ticks at start edge +4, +8, +12.
    do_start();
    s = cyc;
    check("run_running", int'(running), 1);
    push_tick(s + 4);
    push_tick(s + 8);
    push_tick(s + 12);

    // Pause with prescaler at 2 (sampled at edge s+15), hold 10 cycles.
    to_neg(s + 14);
    do_start();
    check("pause_running", int'(running), 0);
    to_neg(s + 24);
    do_start();
    p = cyc;
    check("resume_running", int'(running), 1);
    push_tick(p + 2);
    push_tick(p + 6);

    // Timeout sampled exactly when the prescaler is at terminal count (edge p+10).
    to_neg(p + 9);
    timeout = 1'b1;
    @(negedge clk);
    check("timeout_done", int'(done), 1);
    check("timeout_running", int'(running), 0);
    do_start();
    @(negedge clk);
    check("done_start_done", int'(done), 1);
    check("done_start_running", int'(running), 0);

    // Re-entry from DONE, run, then load+start together.
    timeout = 1'b0;
    do_load(4'd5, 4'b1000);
    check("reentry_done", int'(done), 0);
    do_load(4'd0, 4'b0100);
    do_load(4'd0, 4'b0010);
    do_load(4'd0, 4'b0001);
    do_start();
    s2 = cyc;
    @(negedge clk);
    digitIn = 4'd7; loadBtn = 1'b1; startBtn = 1'b1;
    exp_q.push_back('{at: cyc + 1, tick: 1'b0, en: 4'b1000, bin: 4'd7});
    @(negedge clk);
    loadBtn = 1'b0; startBtn = 1'b0;
    check("prio_running", int'(running), 0);
    check("prio_at", cyc, s2 + 2);
    do_load(4'd0, 4'b0100);
    do_load(4'd0, 4'b0010);
    do_load(4'd0, 4'b0001);

    // All-zero style start: timeout already high, one RUN cycle then DONE.
    timeout = 1'b1;
    do_start();
    t = cyc;
    check("zero_run_running", int'(running), 1);
    @(negedge clk);
    check("zero_done", int'(done), 1);
    check("zero_running", int'(running), 0);
    check("zero_at", cyc, t + 1);
    timeout = 1'b0;

    // Async reset between edges while a tick pulse is high.
    do_load(4'd2, 4'b1000);
    do_load(4'd0, 4'b0100);
    do_load(4'd0, 4'b0010);
    do_load(4'd1, 4'b0001);
    do_start();
    s3 = cyc;
    push_tick(s3 + 4);
    to_neg(s3 + 4);
    #2 rst = 1'b0;
    #1;
    check("arst_decTick", int'(decTick), 0);
    check("arst_loadEn", int'(loadEn), 0);
    check("arst_binaryInp", int'(binaryInp), 0);
    check("arst_running", int'(running), 0);
    check("arst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_load(4'd9, 4'b1000);

    repeat (3) @(negedge clk);
    check("missing_pulses", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
